ex_mem_pipe: RTL and testbench

Execute-to-memory pipeline register with a multi-cycle hold controller for the M-extension ALU. It captures the ALU result and the control and data fields of the instruction in EX, and launches them into the MEM stage. It also asserts a stall to IF/ID/EX while a MUL/DIV/REM operation iterates inside the ALU. It sits directly downstream of the ALU and consumes its `ALUresult`, `Zero`, `mul_done` and `div_done`.

---
 rtl/rv_pkg.sv | 24 ++
 rtl/ex_mem_pipe_md_lat_counter.sv | 20 ++
 rtl/ex_mem_pipe.sv | 96 +++++++++
 tb/tb_ex_mem_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, EX/MEM control bundle and hold-controller state encoding.
package rv_pkg;
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       zero;
    logic [4:0] rd;
  } ex_mem_t;
endpackage

// File: rtl/ex_mem_pipe_md_lat_counter.sv
// md_lat_counter: saturating 8-bit cycle counter with clear, enable and limit compare.
module md_lat_counter #(
  parameter int MAX_LAT = 127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] cnt_o,
  output logic       hit_o
);
  localparam logic [7:0] LIM = (MAX_LAT > 255) ? 8'd255 : 8'(MAX_LAT);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 8'd0 : (en_i && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign hit_o = cnt_q >= LIM;
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with stall/hold control for multi-cycle M-ops.
module ex_mem_pipe import rv_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int MAX_LAT = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_alu_ctrl,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] ex_pc_plus4,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              mul_done,
  input  logic              div_done,
  input  logic              flush_ex,
  output logic              stall_ex,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic [4:0]        mem_rd,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [DATA_W-1:0] mem_pc_plus4,
  output logic              mem_zero,
  output logic              md_timeout,
  output logic [7:0]        md_lat
);
  logic [1:0]        st_q, st_d;
  ex_mem_t           ctl_q, ctl_d, ex_ctl;
  logic [DATA_W-1:0] res_q, res_d, sd_q, sd_d, pc_q, pc_d;
  logic [7:0]        lat_q, lat_d, cnt;
  logic              tmo_q, tmo_d;
  logic              hit, is_md, md_done, idle, load, md_cap;
  assign is_md   = ex_valid & (ex_alu_ctrl >= ALU_MUL);
  assign md_done = mul_done | div_done;
  assign idle    = st_q == ST_IDLE;
  assign md_cap  = md_done && !flush_ex && (idle ? is_md : st_q == ST_BUSY);
  assign load    = (idle && !is_md) || md_cap;
  assign ex_ctl  = '{valid: ex_valid & ~flush_ex, reg_write: ex_reg_write, mem_read: ex_mem_read,
                     mem_write: ex_mem_write, mem_to_reg: ex_mem_to_reg, zero: alu_zero, rd: ex_rd};
  assign stall_ex = idle ? (is_md & ~md_done) : (~md_done & ~hit);
  md_lat_counter #(.MAX_LAT(MAX_LAT)) u_cnt (
    .clk(clk), .rst(rst), .clr_i(idle), .en_i(!idle), .cnt_o(cnt), .hit_o(hit)
  );
  always_comb begin
    ctl_d = load ? ex_ctl : '0;
    if (md_cap) ctl_d.valid = 1'b1;
    res_d = load ? alu_result : res_q;
    sd_d  = load ? ex_store_data : sd_q;
    pc_d  = load ? ex_pc_plus4 : pc_q;
    lat_d = md_cap ? (idle ? 8'd0 : cnt) : lat_q;
    tmo_d = tmo_q | (!idle && !md_done && hit);
    // A timeout or a completion always returns to IDLE; the ALU iteration itself is never aborted.
    st_d  = idle ? ((is_md && !md_done) ? (flush_ex ? ST_DRAIN : ST_BUSY) : ST_IDLE)
          : (md_done || hit || st_q == 2'd3) ? ST_IDLE
          : (flush_ex ? ST_DRAIN : st_q);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q  <= ST_IDLE;
      ctl_q <= '0;
      res_q <= '0;
      sd_q  <= '0;
      pc_q  <= '0;
      lat_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ctl_q <= ctl_d;
      res_q <= res_d;
      sd_q  <= sd_d;
      pc_q  <= pc_d;
      lat_q <= lat_d;
      tmo_q <= tmo_d;
    end
  assign mem_valid      = ctl_q.valid;
  assign mem_reg_write  = ctl_q.reg_write;
  assign mem_mem_read   = ctl_q.mem_read;
  assign mem_mem_write  = ctl_q.mem_write;
  assign mem_mem_to_reg = ctl_q.mem_to_reg;
  assign mem_rd         = ctl_q.rd;
  assign mem_zero       = ctl_q.zero;
  assign mem_alu_result = res_q;
  assign mem_store_data = sd_q;
  assign mem_pc_plus4   = pc_q;
  assign md_timeout     = tmo_q;
  assign md_lat         = lat_q;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: randomized scenario bench for ex_mem_pipe with a behavioural ALU/pipeline model.
module tb_ex_mem_pipe;
  import rv_pkg::*;
  localparam int W  = 32;
  localparam int ML = 100;
  logic clk = 1'b0, rst = 1'b0;
  logic ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0, ex_mem_to_reg = 0;
  logic [4:0] ex_alu_ctrl = '0, ex_rd = '0;
  logic [W-1:0] ex_store_data = '0, ex_pc_plus4 = '0, alu_result = '0;
  logic alu_zero = 0, mul_done = 0, div_done = 0, flush_ex = 0;
  logic stall_ex, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_zero, md_timeout;
  logic [4:0] mem_rd;
  logic [W-1:0] mem_alu_result, mem_store_data, mem_pc_plus4;
  logic [7:0] md_lat;
  int n_cmp = 0, n_bad = 0;
  int exp_lat = 0;

  ex_mem_pipe #(.DATA_W(W), .MAX_LAT(ML)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_store_data(ex_store_data), .ex_pc_plus4(ex_pc_plus4),
    .alu_result(alu_result), .alu_zero(alu_zero), .mul_done(mul_done), .div_done(div_done),
    .flush_ex(flush_ex), .stall_ex(stall_ex), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_pc_plus4(mem_pc_plus4), .mem_zero(mem_zero), .md_timeout(md_timeout), .md_lat(md_lat)
  );

  always #5 clk = ~clk;

  // Reference RISC-V M-extension results, including the divide-by-zero and overflow corner cases.
  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      ALU_MUL:    begin p = 64'(longint'(sa) * longint'(sb)); return p[31:0]; end
      ALU_MULH:   begin p = 64'(longint'(sa) * longint'(sb)); return p[63:32]; end
      ALU_MULHSU: begin p = 64'(longint'(sa) * longint'({32'd0, b})); return p[63:32]; end
      ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:    return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      ALU_REMU:   return (b == 0) ? a : a % b;
      default:    return a + b;
    endcase
  endfunction

  function automatic int md_delay(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 66;
    if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 3;
    return 35;
  endfunction

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_zero} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b expected 000000", {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_zero});
    end
    n_cmp++;
    if ({mem_alu_result, mem_store_data, mem_pc_plus4, mem_rd} !== '0) begin
      n_bad++; $display("FAIL reset_data got %h %h %h rd %0d expected 0", mem_alu_result, mem_store_data, mem_pc_plus4, mem_rd);
    end
    n_cmp++;
    if ({md_timeout, md_lat, stall_ex} !== 10'b0) begin
      n_bad++; $display("FAIL reset_status got tmo %b lat %0d stall %b expected 0", md_timeout, md_lat, stall_ex);
    end
    rst = 1'b1;
  endtask

  task automatic test_add;
    ex_valid = 1; ex_alu_ctrl = ALU_ADD; ex_rd = 5; ex_reg_write = 1; ex_mem_read = 0; ex_mem_write = 0;
    ex_mem_to_reg = 0; alu_result = 32'h0000_000C; alu_zero = 0; mul_done = 0; div_done = 0; flush_ex = 0;
    ex_store_data = $urandom; ex_pc_plus4 = $urandom;
    #3;
    n_cmp++;
    if (stall_ex !== 1'b0) begin n_bad++; $display("FAIL add_stall got %b expected 0", stall_ex); end
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_valid, mem_rd, mem_alu_result} !== {1'b1, 5'd5, 32'h0000_000C}) begin
      n_bad++; $display("FAIL add_result got v %b rd %0d res %h expected v 1 rd 5 res 0000000c", mem_valid, mem_rd, mem_alu_result);
    end
    ex_valid = 0;
  endtask

  task automatic test_single_random;
    logic v, f;
    for (int k = 0; k < 24; k++) begin
      v = ($urandom % 4) != 0;
      f = ($urandom % 5) == 0;
      ex_valid = v;
      ex_alu_ctrl = v ? 5'($urandom_range(0, 15)) : 5'($urandom);
      ex_rd = 5'($urandom); ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_mem_write = 1'($urandom); ex_mem_to_reg = 1'($urandom); alu_zero = 1'($urandom);
      ex_store_data = $urandom; ex_pc_plus4 = $urandom; alu_result = $urandom; flush_ex = f;
      mul_done = ($urandom % 6) == 0; div_done = ($urandom % 6) == 0;
      #3;
      n_cmp++;
      if (stall_ex !== 1'b0) begin n_bad++; $display("FAIL single_stall it %0d got %b expected 0", k, stall_ex); end
      @(posedge clk); #1;
      n_cmp++;
      if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_zero, mem_rd} !==
          {v & ~f, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, alu_zero, ex_rd}) begin
        n_bad++; $display("FAIL single_ctrl it %0d got %b %b%b%b%b z%b rd%0d expected %b %b%b%b%b z%b rd%0d", k,
          mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_zero, mem_rd,
          v & ~f, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, alu_zero, ex_rd);
      end
      n_cmp++;
      if ({mem_alu_result, mem_store_data, mem_pc_plus4} !== {alu_result, ex_store_data, ex_pc_plus4}) begin
        n_bad++; $display("FAIL single_data it %0d got %h %h %h expected %h %h %h", k,
          mem_alu_result, mem_store_data, mem_pc_plus4, alu_result, ex_store_data, ex_pc_plus4);
      end
    end
    ex_valid = 0; flush_ex = 0; mul_done = 0; div_done = 0;
  endtask

  // Issue one M-op whose completion pulse arrives d cycles after issue; fl is the cycle flush_ex pulses (-1: never).
  task automatic test_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int d, input int fl);
    logic [31:0] r, pc;
    logic [4:0] rd;
    logic keep;
    r = alu_ref(op, a, b);
    rd = 5'($urandom_range(1, 31));
    pc = $urandom;
    keep = !(fl >= 0 && fl <= d);
    ex_valid = 1; ex_alu_ctrl = op; ex_rd = rd; ex_reg_write = 1; ex_mem_read = 0; ex_mem_write = 0;
    ex_mem_to_reg = 0; ex_store_data = b; ex_pc_plus4 = pc; alu_zero = (r == 0);
    for (int i = 0; i <= d; i++) begin
      flush_ex = (i == fl);
      mul_done = (i == d) && !op[2];
      div_done = (i == d) && op[2];
      alu_result = (i == d) ? r : $urandom;
      #3;
      n_cmp++;
      if (stall_ex !== (i < d)) begin
        n_bad++; $display("FAIL md_stall op %b cyc %0d got %b expected %b", op, i, stall_ex, i < d);
      end
      @(posedge clk); #1;
      if (i < d) begin
        n_cmp++;
        if ({mem_valid, mem_reg_write, mem_mem_write} !== 3'b0) begin
          n_bad++; $display("FAIL md_bubble op %b cyc %0d got %b expected 000", op, i, {mem_valid, mem_reg_write, mem_mem_write});
        end
      end
    end
    n_cmp++;
    if (mem_valid !== keep) begin n_bad++; $display("FAIL md_valid op %b got %b expected %b", op, mem_valid, keep); end
    if (keep) begin
      exp_lat = d - 1;
      n_cmp++;
      if ({mem_alu_result, mem_rd, mem_pc_plus4, mem_reg_write} !== {r, rd, pc, 1'b1}) begin
        n_bad++; $display("FAIL md_result op %b got %h rd %0d pc %h rw %b expected %h rd %0d pc %h rw 1", op,
          mem_alu_result, mem_rd, mem_pc_plus4, mem_reg_write, r, rd, pc);
      end
    end
    n_cmp++;
    if (md_lat !== 8'(exp_lat)) begin n_bad++; $display("FAIL md_lat op %b got %0d expected %0d", op, md_lat, exp_lat); end
    ex_valid = 0; flush_ex = 0; mul_done = 0; div_done = 0;
  endtask

  task automatic test_mul;
    test_md(ALU_MUL, 32'hFFFF_FFFD, 32'd7, md_delay(ALU_MUL, 32'hFFFF_FFFD, 32'd7), -1);
    n_cmp++;
    if (mem_alu_result !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul_neg got %h expected ffffffeb", mem_alu_result); end
  endtask

  task automatic test_back_to_back;
    test_md(ALU_DIVU, 32'd100, 32'd7, 35, -1);
    n_cmp++;
    if (mem_alu_result !== 32'd14) begin n_bad++; $display("FAIL divu_b2b got %0d expected 14", mem_alu_result); end
    test_md(ALU_REMU, 32'd100, 32'd7, 35, -1);
    n_cmp++;
    if (mem_alu_result !== 32'd2) begin n_bad++; $display("FAIL remu_b2b got %0d expected 2", mem_alu_result); end
    test_md(ALU_DIV, 32'd9, 32'd0, 3, -1);
    test_md(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 3, -1);
  endtask

  task automatic test_flush;
    test_md(ALU_DIV, 32'd100, 32'd7, 35, 10);
    test_add;
    test_md(ALU_DIVU, 32'd55, 32'd4, 35, 0);
    test_md(ALU_REMU, 32'd55, 32'd4, 35, 35);
    test_add;
  endtask

  task automatic test_random_md;
    logic [4:0] op;
    logic [31:0] a, b;
    int d;
    for (int k = 0; k < 8; k++) begin
      op = ALU_MUL + 5'($urandom_range(0, 7));
      a = $urandom;
      b = (($urandom % 4) == 0) ? 32'd0 : $urandom;
      d = ($urandom % 2) ? md_delay(op, a, b) : $urandom_range(1, 70);
      test_md(op, a, b, d, (($urandom % 4) == 0) ? $urandom_range(0, d) : -1);
    end
  endtask

  task automatic test_timeout;
    ex_valid = 1; ex_alu_ctrl = ALU_MULHU; ex_rd = 9; ex_reg_write = 1;
    mul_done = 0; div_done = 0; flush_ex = 0;
    for (int i = 0; i <= ML + 1; i++) begin
      alu_result = $urandom;
      #3;
      n_cmp++;
      if (stall_ex !== (i <= ML)) begin n_bad++; $display("FAIL tmo_stall cyc %0d got %b expected %b", i, stall_ex, i <= ML); end
      @(posedge clk); #1;
      if (i == ML) begin
        n_cmp++;
        if (md_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_early got %b expected 0", md_timeout); end
      end
    end
    n_cmp++;
    if ({md_timeout, mem_valid, mem_reg_write} !== 3'b100) begin
      n_bad++; $display("FAIL tmo_flag got tmo %b v %b rw %b expected 1 0 0", md_timeout, mem_valid, mem_reg_write);
    end
    ex_valid = 0;
    #3;
    n_cmp++;
    if (stall_ex !== 1'b0) begin n_bad++; $display("FAIL tmo_release got %b expected 0", stall_ex); end
    test_add;
    n_cmp++;
    if ({md_timeout, md_lat} !== {1'b1, 8'(exp_lat)}) begin
      n_bad++; $display("FAIL tmo_sticky got tmo %b lat %0d expected 1 %0d", md_timeout, md_lat, exp_lat);
    end
  endtask

  task automatic test_reset_mid_op;
    ex_valid = 1; ex_alu_ctrl = ALU_MUL; ex_rd = 3; ex_reg_write = 1; mul_done = 0; div_done = 0; flush_ex = 0;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; end
    #3;
    n_cmp++;
    if (stall_ex !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stall got %b expected 1", stall_ex); end
    rst = 1'b0; ex_valid = 0;
    #1;
    n_cmp++;
    if ({mem_valid, mem_reg_write, mem_rd, mem_alu_result, mem_pc_plus4, md_timeout, md_lat, stall_ex} !== '0) begin
      n_bad++; $display("FAIL rst_mid got v %b rd %0d res %h tmo %b lat %0d stall %b expected all 0",
        mem_valid, mem_rd, mem_alu_result, md_timeout, md_lat, stall_ex);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_lat = 0;
    test_md(ALU_MUL, 32'hFFFF_FFFD, 32'd7, 66, -1);
    n_cmp++;
    if ({mem_alu_result, md_lat, md_timeout} !== {32'hFFFF_FFEB, 8'd65, 1'b0}) begin
      n_bad++; $display("FAIL rst_reissue got %h lat %0d tmo %b expected ffffffeb lat 65 tmo 0", mem_alu_result, md_lat, md_timeout);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add;
    test_single_random;
    test_mul;
    test_back_to_back;
    test_flush;
    test_random_md;
    test_timeout;
    test_reset_mid_op;
    test_add;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
